// File: rtl/conv_pkg.sv
// Shared types and defaults for the 1D convolution input feeder.
// Holds the feeder state encoding, config-port select codes and sizing helpers.
package conv_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int N_SAMPLES_DEF = 16;
  localparam int K_TAPS_DEF    = 3;
  localparam int ADDR_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    LOAD_KERNEL = 2'd1,
    STREAM      = 2'd2
  } feeder_state_t;

  localparam logic CFG_SEL_SAMPLE = 1'b0;
  localparam logic CFG_SEL_KERNEL = 1'b1;

  // Index width that stays at least one bit wide for single-entry tables.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_sample_buf.sv
// Sample storage for the feeder: N x DATA_W register array, one write port,
// combinational read. Contents are deliberately not reset.
module conv_sample_buf #(
  parameter int DATA_W = 32,
  parameter int N      = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv_input_feeder.sv
// Upstream feeder for computing_core: presents K kernel taps on consecutive
// cycles after start, then streams N samples, advancing only on core_en.
module conv_input_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int K_TAPS    = K_TAPS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  input  logic              core_en,
  output logic [DATA_W-1:0] data_kernel,
  output logic              kernel_valid,
  output logic [DATA_W-1:0] data_in_0,
  output logic              busy,
  output logic              feed_done
);

  localparam int IDX_W = idx_width(N_SAMPLES);
  localparam int T_W   = idx_width(K_TAPS);

  feeder_state_t     state_reg, state_next;
  logic [T_W-1:0]    t_reg, t_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] dk_reg, dk_next;
  logic              kv_reg, kv_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] kernel_mem [K_TAPS];

  logic              cfg_open;
  logic              sample_we;
  logic              kernel_we;
  logic              idx_last;
  logic              t_last;
  logic [T_W-1:0]    t_inc;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] sample_rd;

  // Config writes are only accepted while idle and inside the addressed table.
  assign cfg_open  = cfg_we && (state_reg == IDLE);
  assign sample_we = cfg_open && (cfg_sel == CFG_SEL_SAMPLE) && (32'(cfg_addr) < 32'(N_SAMPLES));
  assign kernel_we = cfg_open && (cfg_sel == CFG_SEL_KERNEL) && (32'(cfg_addr) < 32'(K_TAPS));

  assign idx_last = (idx_reg == IDX_W'(N_SAMPLES - 1));
  assign t_last   = (t_reg == T_W'(K_TAPS - 1));
  assign t_inc    = t_reg + T_W'(1);

  // The single read port serves sample[0] at start and sample[idx+1] while
  // streaming; it never runs past the last sample.
  assign rd_addr = ((state_reg == STREAM) && !idx_last) ? (idx_reg + IDX_W'(1)) : '0;

  conv_sample_buf #(
    .DATA_W (DATA_W),
    .N      (N_SAMPLES),
    .AW     (IDX_W)
  ) u_sample_buf (
    .clk     (clk),
    .we      (sample_we),
    .wr_addr (cfg_addr[IDX_W-1:0]),
    .wr_data (cfg_wdata),
    .rd_addr (rd_addr),
    .rd_data (sample_rd)
  );

  always_ff @(posedge clk) begin
    if (kernel_we) begin
      kernel_mem[cfg_addr[T_W-1:0]] <= cfg_wdata;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    idx_next   = idx_reg;
    dk_next    = dk_reg;
    kv_next    = kv_reg;
    din_next   = din_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD_KERNEL;
          t_next     = '0;
          idx_next   = '0;
          din_next   = sample_rd;
          dk_next    = kernel_mem[0];
          kv_next    = 1'b1;
        end
      end
      LOAD_KERNEL: begin
        if (t_last) begin
          kv_next    = 1'b0;
          state_next = STREAM;
        end else begin
          t_next  = t_inc;
          dk_next = kernel_mem[t_inc];
        end
      end
      STREAM: begin
        if (core_en) begin
          if (idx_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
            din_next = sample_rd;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      idx_reg   <= '0;
      dk_reg    <= '0;
      kv_reg    <= 1'b0;
      din_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      idx_reg   <= idx_next;
      dk_reg    <= dk_next;
      kv_reg    <= kv_next;
      din_reg   <= din_next;
      done_reg  <= done_next;
    end
  end

  assign data_kernel  = dk_reg;
  assign kernel_valid = kv_reg;
  assign data_in_0    = din_reg;
  assign busy         = (state_reg != IDLE);
  assign feed_done    = done_reg;

endmodule

// File: tb/tb_conv_input_feeder.sv
// Self-checking bench for conv_input_feeder: directed scenarios plus randomized
// runs, compared every cycle against a run-level behavioural model.
module tb_conv_input_feeder;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam int K  = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic          cfg_sel = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          start = 1'b0;
  logic          core_en = 1'b0;
  logic [DW-1:0] data_kernel;
  logic          kernel_valid;
  logic [DW-1:0] data_in_0;
  logic          busy;
  logic          feed_done;

  always #5 clk = ~clk;

  conv_input_feeder #(.DATA_W(DW), .N_SAMPLES(N), .K_TAPS(K), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .core_en      (core_en),
    .data_kernel  (data_kernel),
    .kernel_valid (kernel_valid),
    .data_in_0    (data_in_0),
    .busy         (busy),
    .feed_done    (feed_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: tables as the config port should leave them, and the
  // observable progress of a run (taps shown so far, sample position).
  logic [DW-1:0] samp [N];
  logic [DW-1:0] kern [K];
  bit            m_busy;
  bit            m_loading;
  int            m_taps;
  int            m_pos;
  logic [DW-1:0] m_dk;
  logic [DW-1:0] m_din;
  logic          m_kv;
  logic          m_done;

  task automatic model_reset();
    m_busy = 0; m_loading = 0; m_taps = 0; m_pos = 0;
    m_dk = '0; m_din = '0; m_kv = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_loading = 1; m_taps = 1;
        m_dk = kern[0]; m_kv = 1'b1; m_pos = 0; m_din = samp[0];
      end
      if (cfg_we) begin
        if (cfg_sel == 1'b0 && int'(cfg_addr) < N) samp[cfg_addr] = cfg_wdata;
        else if (cfg_sel == 1'b1 && int'(cfg_addr) < K) kern[cfg_addr] = cfg_wdata;
      end
    end else if (m_loading) begin
      if (m_taps == K) begin
        m_loading = 0; m_kv = 1'b0;
      end else begin
        m_dk = kern[m_taps]; m_taps++;
      end
    end else if (core_en) begin
      if (m_pos == N - 1) begin
        m_busy = 0; m_done = 1'b1;
      end else begin
        m_pos++; m_din = samp[m_pos];
      end
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_kernel"}, data_kernel, m_dk);
    check({tag, ".kernel_valid"}, DW'(kernel_valid), DW'(m_kv));
    check({tag, ".data_in_0"}, data_in_0, m_din);
    check({tag, ".busy"}, DW'(busy), DW'(m_busy));
    check({tag, ".feed_done"}, DW'(feed_done), DW'(m_done));
  endtask

  task automatic step(input logic we, input logic sel, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic st, input logic en);
    cfg_we = we; cfg_sel = sel; cfg_addr = addr; cfg_wdata = wd; start = st; core_en = en;
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    check_all("cyc");
  endtask

  task automatic wr(input logic sel, input int addr, input logic [DW-1:0] d);
    step(1'b1, sel, AW'(addr), d, 1'b0, 1'b0);
  endtask

  task automatic finish_run();
    for (int g = 0; g < 200 && m_busy; g++) step(0, 0, '0, '0, 0, 1);
  endtask

  task automatic run_to_pos(input int p);
    for (int g = 0; g < 200 && m_busy && m_pos < p; g++) step(0, 0, '0, '0, 0, 1);
  endtask

  initial begin
    int done_cnt;
    model_reset();
    #2;
    check_all("reset");
    #10 reset = 1'b1;

    // 1: basic run
    for (int i = 0; i < N; i++) wr(0, i, DW'(i));
    for (int i = 0; i < K; i++) wr(1, i, DW'(i + 1));
    wr(1, 3, 32'd777);
    step(0, 0, '0, '0, 1, 1);
    check("t1_tap0", data_kernel, 32'd1);
    step(0, 0, '0, '0, 0, 1);
    check("t1_tap1", data_kernel, 32'd2);
    step(0, 0, '0, '0, 0, 1);
    check("t1_tap2", data_kernel, 32'd3);
    check("t1_din_load", data_in_0, 32'd0);
    done_cnt = 0;
    for (int g = 0; g < 200 && m_busy; g++) begin
      step(0, 0, '0, '0, 0, 1);
      if (feed_done) done_cnt++;
    end
    check("t1_done_count", DW'(done_cnt), 32'd1);
    check("t1_last_sample", data_in_0, 32'd15);

    // 5: end boundary
    for (int i = 0; i < 5; i++) step(0, 0, '0, '0, 0, 1);
    check("t5_hold", data_in_0, 32'd15);

    // 6: back-to-back
    step(0, 0, '0, '0, 1, 1);
    for (int g = 0; g < 200 && !m_done; g++) step(0, 0, '0, '0, 0, 1);
    step(0, 0, '0, '0, 1, 1);
    check("t6_kv", DW'(kernel_valid), 32'd1);
    check("t6_tap0", data_kernel, 32'd1);
    finish_run();

    // 2: stall
    step(0, 0, '0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 0);
    step(0, 0, '0, '0, 0, 1);
    check("t2_d1", data_in_0, 32'd1);
    step(0, 0, '0, '0, 0, 1);
    check("t2_d2", data_in_0, 32'd2);
    step(0, 0, '0, '0, 0, 0);
    check("t2_hold_a", data_in_0, 32'd2);
    step(0, 0, '0, '0, 0, 0);
    check("t2_hold_b", data_in_0, 32'd2);
    step(0, 0, '0, '0, 0, 1);
    check("t2_d3", data_in_0, 32'd3);
    finish_run();

    // 3: blocked writes and start while busy
    step(0, 0, '0, '0, 1, 1);
    run_to_pos(3);
    step(1, 0, AW'(5), 32'd99, 1, 0);
    run_to_pos(5);
    check("t3_blocked", data_in_0, 32'd5);
    finish_run();
    wr(0, 5, 32'd99);
    step(0, 0, '0, '0, 1, 1);
    run_to_pos(5);
    check("t3_written", data_in_0, 32'd99);
    finish_run();
    wr(0, 5, 32'd5);

    // 4: mid-run reset
    step(0, 0, '0, '0, 1, 1);
    run_to_pos(7);
    check("t4_at7", data_in_0, 32'd7);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("t4_async");
    step(0, 0, '0, '0, 1, 1);
    step(0, 0, '0, '0, 0, 1);
    reset = 1'b1;
    step(0, 0, '0, '0, 1, 1);
    check("t4_tap0", data_kernel, 32'd1);
    finish_run();
    check("t4_last", data_in_0, 32'd15);

    // randomized runs: fresh tables, random stalls, stray writes/starts while busy
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) wr(0, i, $urandom);
      for (int i = 0; i < K; i++) wr(1, i, $urandom);
      wr(1, 3, $urandom);
      step(0, 0, '0, '0, 1, 1'($urandom_range(0, 1)));
      for (int g = 0; g < 300 && m_busy; g++)
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
             $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 60));
      check("rand_idle", DW'(busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
